// File: rtl/linear_classifier_engine_if.sv
// Bus bundle between the classifier engine and its weight/bias/image RAMs, control and result display.
// master = engine side, slave = memories/controller side.
interface linear_classifier_engine_if #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_INPUTS  = 784,
  parameter int LANES       = 1,
  parameter int PIX_W       = 8,
  parameter int WGT_W       = 8,
  parameter int ACC_W       = 32
);
  localparam int BEATS = NUM_INPUTS / LANES;
  localparam int CLS_W = $clog2(NUM_CLASSES);
  localparam int WA_W  = $clog2(NUM_CLASSES * BEATS);
  localparam int IA_W  = $clog2(BEATS);

  logic [WA_W-1:0]        weight_addr;
  logic [LANES*WGT_W-1:0] weight_data;
  logic [CLS_W-1:0]       bias_addr;
  logic [ACC_W-1:0]       bias_data;
  logic [IA_W-1:0]        input_addr;
  logic [LANES*PIX_W-1:0] input_pixel;
  logic                   weights_ready;
  logic                   start_inference;
  logic                   abort;
  logic [CLS_W-1:0]       predicted_digit;
  logic [ACC_W-1:0]       max_score;
  logic [ACC_W-1:0]       class_score;
  logic [CLS_W-1:0]       class_idx;
  logic                   class_valid;
  logic                   inference_done;
  logic                   busy;

  modport master (
    output weight_addr, bias_addr, input_addr,
    output predicted_digit, max_score, class_score, class_idx, class_valid, inference_done, busy,
    input  weight_data, bias_data, input_pixel, weights_ready, start_inference, abort
  );

  modport slave (
    input  weight_addr, bias_addr, input_addr,
    input  predicted_digit, max_score, class_score, class_idx, class_valid, inference_done, busy,
    output weight_data, bias_data, input_pixel, weights_ready, start_inference, abort
  );
endinterface

// File: rtl/linear_classifier_engine.sv
// Multi-lane linear classifier: score[c] = sat(bias[c] + sum w[c][i]*x[i]), argmax over classes.
//  state      | meaning
//  IDLE       | waiting for start_inference with weights_ready
//  LOAD_BIAS  | addresses for class set, accumulator cleared
//  COMPUTE    | BEATS+1 cycles: issue beat addresses, accumulate one cycle later
//  ADD_BIAS   | acc <= sat(acc + bias)
//  NEXT_CLASS | publish class score, track best, advance class
//  DONE       | publish argmax, pulse inference_done
module linear_classifier_engine #(
  parameter int NUM_CLASSES = 10,
  parameter int NUM_INPUTS  = 784,
  parameter int LANES       = 1,
  parameter int PIX_W       = 8,
  parameter int WGT_W       = 8,
  parameter int ACC_W       = 32
) (
  input logic                        clk,
  input logic                        rst,
  linear_classifier_engine_if.master bus
);
  localparam int BEATS  = NUM_INPUTS / LANES;
  localparam int CLS_W  = $clog2(NUM_CLASSES);
  localparam int WA_W   = $clog2(NUM_CLASSES * BEATS);
  localparam int IA_W   = $clog2(BEATS);
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int PROD_W = WGT_W + PIX_W + 1;
  localparam int SUM_W  = ACC_W + PROD_W + $clog2(LANES) + 2;

  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_BIAS  = 3'd1;
  localparam logic [2:0] S_COMPUTE    = 3'd2;
  localparam logic [2:0] S_ADD_BIAS   = 3'd3;
  localparam logic [2:0] S_NEXT_CLASS = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]               state;
  logic [CLS_W-1:0]         cls;
  logic [WA_W-1:0]          weight_addr;
  logic [IA_W-1:0]          input_addr;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  bias_q;
  logic signed [ACC_W-1:0]  best_score;
  logic [CLS_W-1:0]         best_idx;
  logic [CLS_W-1:0]         predicted_digit;
  logic signed [ACC_W-1:0]  max_score;
  logic signed [ACC_W-1:0]  class_score;
  logic [CLS_W-1:0]         class_idx;
  logic                     class_valid;
  logic                     inference_done;
  logic                     busy;

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  acc_beat;
  logic signed [ACC_W-1:0]  acc_bias;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  // Pixels are unsigned, so each gets a zero sign bit before the signed multiply.
  always_comb begin
    prod     = '0;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      prod = PROD_W'($signed(bus.weight_data[k*WGT_W +: WGT_W])) *
             PROD_W'($signed({1'b0, bus.input_pixel[k*PIX_W +: PIX_W]}));
      lane_sum = lane_sum + SUM_W'(prod);
    end
    acc_beat = sat(SUM_W'(acc) + lane_sum);
    acc_bias = sat(SUM_W'(acc) + SUM_W'(bias_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      cls             <= '0;
      weight_addr     <= '0;
      input_addr      <= '0;
      cnt             <= '0;
      acc             <= '0;
      bias_q          <= '0;
      best_score      <= '0;
      best_idx        <= '0;
      predicted_digit <= '0;
      max_score       <= '0;
      class_score     <= '0;
      class_idx       <= '0;
      class_valid     <= 1'b0;
      inference_done  <= 1'b0;
      busy            <= 1'b0;
    end else begin
      class_valid    <= 1'b0;
      inference_done <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start_inference && bus.weights_ready && !bus.abort) begin
              state       <= S_LOAD_BIAS;
              busy        <= 1'b1;
              cls         <= '0;
              weight_addr <= '0;
              input_addr  <= '0;
            end
          end
          S_LOAD_BIAS: begin
            acc   <= '0;
            cnt   <= CNT_W'(BEATS);
            state <= S_COMPUTE;
          end
          S_COMPUTE: begin
            // cnt counts down from BEATS; cycle index within COMPUTE is BEATS-cnt
            if (cnt == CNT_W'(BEATS)) bias_q <= $signed(bus.bias_data);
            else                      acc    <= acc_beat;
            if (cnt > CNT_W'(1)) begin
              weight_addr <= weight_addr + WA_W'(1);
              input_addr  <= input_addr + IA_W'(1);
            end
            if (cnt == '0) state <= S_ADD_BIAS;
            else           cnt   <= cnt - CNT_W'(1);
          end
          S_ADD_BIAS: begin
            acc   <= acc_bias;
            state <= S_NEXT_CLASS;
          end
          S_NEXT_CLASS: begin
            class_valid <= 1'b1;
            class_score <= acc;
            class_idx   <= cls;
            if (cls == '0 || acc > best_score) begin
              best_score <= acc;
              best_idx   <= cls;
            end
            if (cls == CLS_W'(NUM_CLASSES - 1)) begin
              state <= S_DONE;
            end else begin
              cls         <= cls + CLS_W'(1);
              weight_addr <= weight_addr + WA_W'(1);
              input_addr  <= '0;
              state       <= S_LOAD_BIAS;
            end
          end
          S_DONE: begin
            predicted_digit <= best_idx;
            max_score       <= best_score;
            inference_done  <= 1'b1;
            busy            <= 1'b0;
            state           <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.weight_addr     = weight_addr;
  assign bus.input_addr      = input_addr;
  assign bus.bias_addr       = cls;
  assign bus.predicted_digit = predicted_digit;
  assign bus.max_score       = max_score;
  assign bus.class_score     = class_score;
  assign bus.class_idx       = class_idx;
  assign bus.class_valid     = class_valid;
  assign bus.inference_done  = inference_done;
  assign bus.busy            = busy;
endmodule

// File: tb/tb_linear_classifier_engine.sv
// Scoreboard bench for linear_classifier_engine: a reference model pushes expected per-class
// scores and argmax at start; a negedge monitor pops and compares when the engine reports them.
module tb_linear_classifier_engine;
  localparam int NC      = 10;
  localparam int NI      = 16;
  localparam int LN      = 2;
  localparam int PW      = 8;
  localparam int WW      = 8;
  localparam int AW      = 16;
  localparam int BEATS   = NI / LN;
  localparam int RUN_LEN = NC * (BEATS + 4) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linear_classifier_engine_if #(.NUM_CLASSES(NC), .NUM_INPUTS(NI), .LANES(LN),
                                .PIX_W(PW), .WGT_W(WW), .ACC_W(AW)) bus ();

  linear_classifier_engine #(.NUM_CLASSES(NC), .NUM_INPUTS(NI), .LANES(LN),
                             .PIX_W(PW), .WGT_W(WW), .ACC_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int wt[NC][NI];
  int px[NI];
  int bs[NC];

  int n_chk  = 0;
  int n_fail = 0;
  int cv_cnt = 0;
  int done_cnt = 0;
  int last_digit = 0;
  int last_max = 0;

  int exp_idx_q[$];
  int exp_score_q[$];
  int exp_digit_q[$];
  int exp_max_q[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Synchronous-read RAM models: data valid the cycle after the address
  always @(posedge clk) begin
    logic [LN*WW-1:0] w;
    logic [LN*PW-1:0] p;
    int c, b, a;
    a = int'(bus.weight_addr);
    c = a / BEATS;
    b = a % BEATS;
    w = '0;
    if (c < NC) for (int k = 0; k < LN; k++) w[k*WW +: WW] = WW'(wt[c][b*LN + k]);
    p = '0;
    for (int k = 0; k < LN; k++) p[k*PW +: PW] = PW'(px[int'(bus.input_addr)*LN + k]);
    bus.weight_data <= w;
    bus.input_pixel <= p;
    bus.bias_data   <= (int'(bus.bias_addr) < NC) ? AW'(bs[int'(bus.bias_addr)]) : '0;
  end

  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int model_score(input int c);
    longint acc = 0;
    for (int b = 0; b < BEATS; b++) begin
      longint s = 0;
      for (int k = 0; k < LN; k++) s += longint'(wt[c][b*LN + k]) * longint'(px[b*LN + k]);
      acc = sat(acc + s);
    end
    return int'(sat(acc + bs[c]));
  endfunction

  task automatic push_expected();
    int best, bidx, sc;
    best = 0;
    bidx = 0;
    for (int c = 0; c < NC; c++) begin
      sc = model_score(c);
      exp_idx_q.push_back(c);
      exp_score_q.push_back(sc);
      if (c == 0 || sc > best) begin
        best = sc;
        bidx = c;
      end
    end
    exp_digit_q.push_back(bidx);
    exp_max_q.push_back(best);
  endtask

  task automatic flush_expected();
    exp_idx_q.delete();
    exp_score_q.delete();
    exp_digit_q.delete();
    exp_max_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.class_valid) begin
        cv_cnt++;
        if (exp_score_q.size() == 0) chk("class_valid_unexpected", bus.class_valid, 0);
        else begin
          chk("class_idx", bus.class_idx, exp_idx_q.pop_front());
          chk("class_score", $signed(bus.class_score), exp_score_q.pop_front());
        end
      end
      if (bus.inference_done) begin
        done_cnt++;
        if (exp_digit_q.size() == 0) chk("done_unexpected", bus.inference_done, 0);
        else begin
          chk("predicted_digit", bus.predicted_digit, exp_digit_q.pop_front());
          chk("max_score", $signed(bus.max_score), exp_max_q.pop_front());
        end
      end
    end
  end

  task automatic start_pulse();
    @(negedge clk) bus.start_inference = 1'b1;
    @(negedge clk) bus.start_inference = 1'b0;
  endtask

  task automatic run_check(input string tag);
    int n;
    bit got;
    push_expected();
    start_pulse();
    chk({tag, "_busy_after_start"}, bus.busy, 1);
    n = 0;
    got = 1'b0;
    while (n < RUN_LEN + 20 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.inference_done) got = 1'b1;
    end
    chk({tag, "_latency"}, n, RUN_LEN);
    chk({tag, "_busy_after_done"}, bus.busy, 0);
    @(negedge clk);
    chk({tag, "_sb_drained"}, exp_score_q.size() + exp_digit_q.size(), 0);
    last_digit = int'(bus.predicted_digit);
    last_max   = int'($signed(bus.max_score));
  endtask

  task automatic fill(input int wlo, input int whi, input int plo, input int phi, input int blo, input int bhi);
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < NI; i++) wt[c][i] = wlo + int'($urandom_range(whi - wlo));
      bs[c] = blo + int'($urandom_range(bhi - blo));
    end
    for (int i = 0; i < NI; i++) px[i] = plo + int'($urandom_range(phi - plo));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_digit"}, bus.predicted_digit, 0);
    chk({tag, "_max"}, bus.max_score, 0);
    chk({tag, "_class_score"}, bus.class_score, 0);
    chk({tag, "_class_valid"}, bus.class_valid, 0);
    chk({tag, "_done"}, bus.inference_done, 0);
    chk({tag, "_waddr"}, bus.weight_addr, 0);
    chk({tag, "_iaddr"}, bus.input_addr, 0);
    chk({tag, "_baddr"}, bus.bias_addr, 0);
  endtask

  initial begin
    int base_cv, base_done, t;
    bus.weights_ready   = 1'b1;
    bus.start_inference = 1'b0;
    bus.abort           = 1'b0;
    fill(0, 0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // start ignored while weights_ready low
    bus.weights_ready = 1'b0;
    start_pulse();
    repeat (3) @(negedge clk);
    chk("start_no_ready_busy", bus.busy, 0);
    bus.weights_ready = 1'b1;

    // abort and start together in IDLE: abort wins
    bus.abort = 1'b1;
    start_pulse();
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_start_idle_busy", bus.busy, 0);
    chk("abort_start_idle_digit", bus.predicted_digit, 0);

    // zero weights, bias ramp: last class wins
    for (int c = 0; c < NC; c++) bs[c] = c * 1000;
    base_cv = cv_cnt;
    run_check("bias_ramp");
    chk("bias_ramp_digit", bus.predicted_digit, 9);
    chk("bias_ramp_max", $signed(bus.max_score), 9000);
    chk("bias_ramp_class_valids", cv_cnt - base_cv, NC);

    // all scores tie: lowest index kept
    for (int c = 0; c < NC; c++) bs[c] = 500;
    run_check("tie");
    chk("tie_digit", bus.predicted_digit, 0);
    chk("tie_max", $signed(bus.max_score), 500);

    // positive and negative saturation
    fill(127, 127, 255, 255, 0, 0);
    run_check("sat_pos");
    chk("sat_pos_max", $signed(bus.max_score), 32767);
    fill(-128, -128, 255, 255, 0, 0);
    run_check("sat_neg");
    chk("sat_neg_max", $signed(bus.max_score), -32768);
    fill(127, 127, 255, 255, -100, -100);
    run_check("sat_then_bias");
    chk("sat_then_bias_max", $signed(bus.max_score), 32667);

    // random data against the model
    fill(-4, 4, 0, 255, -2000, 2000);
    run_check("rand_small");
    fill(-128, 127, 0, 255, -30000, 30000);
    run_check("rand_full");
    fill(-20, 20, 0, 100, -500, 500);
    run_check("rand_mid");

    // weights_ready dropping mid-run is ignored
    fill(-10, 10, 0, 255, -100, 100);
    fork
      run_check("ready_drop");
      begin
        repeat (30) @(negedge clk);
        bus.weights_ready = 1'b0;
      end
    join
    bus.weights_ready = 1'b1;

    // second start pulse while busy is ignored
    fill(-10, 10, 0, 255, -100, 100);
    fork
      run_check("restart_ignored");
      begin
        repeat (30) @(negedge clk);
        bus.start_inference = 1'b1;
        @(negedge clk);
        bus.start_inference = 1'b0;
      end
    join

    // abort at class 4 mid-COMPUTE
    fill(-50, 50, 0, 255, -1000, 1000);
    push_expected();
    base_cv = cv_cnt;
    base_done = done_cnt;
    start_pulse();
    t = 0;
    while (cv_cnt < base_cv + 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - base_done, 0);
    chk("abort_class_valids", cv_cnt - base_cv, 4);
    chk("abort_sb_left", exp_score_q.size(), NC - 4);
    chk("abort_digit_kept", bus.predicted_digit, last_digit);
    chk("abort_max_kept", $signed(bus.max_score), last_max);
    flush_expected();
    run_check("after_abort");

    // reset mid-run, then a clean run
    fill(-50, 50, 0, 255, -1000, 1000);
    push_expected();
    start_pulse();
    repeat (40) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    flush_expected();
    rst = 1'b1;
    @(negedge clk);
    run_check("after_reset");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
